qam_tap_capture: RTL

- Parametrised capture-and-export engine for internal taps of the QAM-16 transmit chain, e.g. mod i/q, filter i/q and the qam output.
- Supports any number of tap channels. On a software arm and a trigger, it records a configurable-length, optionally decimated burst of one selected tap into on-chip RAM.
- The burst is then replayed on an AXI4-Stream master for host-side data export.
- Sits beside the modulator top and replaces hard-wired export ports with one selectable, buffered stream.

---
 rtl/qam_tap_capture.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/qam_tap_capture.sv
// qam_tap_capture: arm/trigger capture of one selected QAM transmit-chain tap
// into on-chip RAM, then replay of the burst on an AXI4-Stream master.
//
// Ports:
//   axi_clk, axi_rst             clock, asynchronous active-high reset
//   tap_valid, tap_data          per-tap strobes and packed signed samples
//   cfg_sel, cfg_decim, cfg_len  tap select, keep 1 of cfg_decim+1, burst length
//   cfg_cont                     re-arm automatically after each drain
//   arm, abort, trig_in          start request, stop request, trigger level
//   m_axis_*                     replay stream (tvalid/tdata/tlast/tready)
//   busy, done, cfg_err, cap_cnt status: not idle, drain-complete pulse,
//                                sticky rejected-arm flag, samples stored
module qam_tap_capture #(
  parameter int NUM_TAPS  = 4,
  parameter int TAP_WIDTH = 18,
  parameter int DEPTH     = 1024,
  parameter int DECIM_W   = 8,
  parameter int SEL_W     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1,
  parameter int LEN_W     = $clog2(DEPTH) + 1
) (
  input  logic                          axi_clk,
  input  logic                          axi_rst,
  input  logic [NUM_TAPS-1:0]           tap_valid,
  input  logic [NUM_TAPS*TAP_WIDTH-1:0] tap_data,
  input  logic [SEL_W-1:0]              cfg_sel,
  input  logic [DECIM_W-1:0]            cfg_decim,
  input  logic [LEN_W-1:0]              cfg_len,
  input  logic                          cfg_cont,
  input  logic                          arm,
  input  logic                          abort,
  input  logic                          trig_in,
  output logic                          m_axis_tvalid,
  output logic [TAP_WIDTH-1:0]          m_axis_tdata,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic [LEN_W-1:0]              cap_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_CAPTURE, ST_DRAIN} state_t;
  state_t state, state_nxt;

  logic [SEL_W-1:0]     sel_q;
  logic [DECIM_W-1:0]   decim_q;
  logic                 cont_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     cap_cnt_q;
  logic [DECIM_W-1:0]   dec_cnt;
  logic                 done_q;
  logic                 cfg_err_q;

  logic [LEN_W-1:0]     rd_cnt;
  logic [LEN_W-1:0]     out_cnt;
  logic                 rd_pend;
  logic [TAP_WIDTH-1:0] ram_q;
  logic [TAP_WIDTH-1:0] fifo_mem [2];
  logic                 fifo_wp, fifo_rp;
  logic [1:0]           fifo_cnt;

  logic [TAP_WIDTH-1:0] mem [DEPTH];

  logic                 sel_valid;
  logic [TAP_WIDTH-1:0] sel_data;
  logic                 cfg_ok, arm_ok, arm_bad;
  logic                 capturing, take, wr_en;
  logic                 beat, last_beat, rd_en;
  logic [1:0]           occ;

  // Mux out the selected tap without indexing by a possibly wider select.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_valid = tap_valid[k];
        sel_data  = tap_data[k*TAP_WIDTH +: TAP_WIDTH];
      end
    end
  end

  assign cfg_ok  = (32'(cfg_sel) < 32'(NUM_TAPS)) && (cfg_len != '0);
  // abort wins over a simultaneous arm, which is then ignored entirely.
  assign arm_ok  = (state == ST_IDLE) && arm && !abort && cfg_ok;
  assign arm_bad = (state == ST_IDLE) && arm && !abort && !cfg_ok;

  // The trigger cycle itself may already deliver the first stored sample.
  assign capturing = !abort && (((state == ST_ARMED) && trig_in) ||
                                ((state == ST_CAPTURE) && (cap_cnt_q != len_q)));
  assign take  = capturing && sel_valid;
  assign wr_en = take && (dec_cnt == '0);

  assign m_axis_tvalid = (state == ST_DRAIN) && (fifo_cnt != 2'd0);
  assign m_axis_tdata  = fifo_mem[fifo_rp];
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt == len_q - LEN_W'(1));
  assign beat      = m_axis_tvalid && m_axis_tready;
  assign last_beat = beat && m_axis_tlast;

  // Reads in flight plus buffered entries never exceed the 2-entry skid;
  // a same-cycle pop frees a slot so a full skid still streams every cycle.
  assign occ   = fifo_cnt + {1'b0, rd_pend};
  assign rd_en = (state == ST_DRAIN) && !abort && (rd_cnt != len_q) &&
                 ((occ < 2'd2) || beat);

  assign busy    = (state != ST_IDLE);
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign cap_cnt = cap_cnt_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (arm_ok) state_nxt = ST_ARMED;
      ST_ARMED:   if (abort) state_nxt = ST_IDLE;
                  else if (trig_in) state_nxt = ST_CAPTURE;
      ST_CAPTURE: if (abort) state_nxt = ST_IDLE;
                  else if (cap_cnt_q == len_q) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (abort) state_nxt = ST_IDLE;
                  else if (last_beat) state_nxt = cont_q ? ST_ARMED : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      sel_q     <= '0;
      decim_q   <= '0;
      cont_q    <= 1'b0;
      len_q     <= '0;
      cap_cnt_q <= '0;
      dec_cnt   <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q <= (state == ST_DRAIN) && !abort && last_beat;
      if (arm_bad)     cfg_err_q <= 1'b1;
      else if (arm_ok) cfg_err_q <= 1'b0;

      if (arm_ok) begin
        sel_q     <= cfg_sel;
        decim_q   <= cfg_decim;
        cont_q    <= cfg_cont;
        len_q     <= (32'(cfg_len) > 32'(DEPTH)) ? DEPTH_LEN : cfg_len;
        cap_cnt_q <= '0;
        dec_cnt   <= '0;
      end else if ((state == ST_DRAIN) && !abort && last_beat && cont_q) begin
        cap_cnt_q <= '0;
        dec_cnt   <= '0;
      end else if (take) begin
        if (dec_cnt == '0) cap_cnt_q <= cap_cnt_q + LEN_W'(1);
        dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DECIM_W'(1);
      end
    end
  end

  // Drain-side read pipeline and skid; everything is flushed outside DRAIN.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      rd_cnt      <= '0;
      out_cnt     <= '0;
      rd_pend     <= 1'b0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else if (state != ST_DRAIN) begin
      rd_cnt   <= '0;
      out_cnt  <= '0;
      rd_pend  <= 1'b0;
      fifo_wp  <= 1'b0;
      fifo_rp  <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) rd_cnt <= rd_cnt + LEN_W'(1);
      if (beat) begin
        out_cnt <= out_cnt + LEN_W'(1);
        fifo_rp <= ~fifo_rp;
      end
      if (rd_pend) begin
        fifo_mem[fifo_wp] <= ram_q;
        fifo_wp <= ~fifo_wp;
      end
      fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, beat};
    end
  end

  // Capture RAM: contents survive reset, so no reset term here.
  always_ff @(posedge axi_clk) begin
    if (wr_en) mem[cap_cnt_q[AW-1:0]] <= sel_data;
    if (rd_en) ram_q <= mem[rd_cnt[AW-1:0]];
  end

endmodule
